// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer and its channel slots.
package demux_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    // Select width never drops below one bit, even for degenerate channel counts.
    function automatic int sel_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_channel_slot.sv
// One-entry output buffer for a single demux channel; optional transfer counter
// under DEMUX_TRANSFER_COUNT_EN.
module demux_channel_slot
    import demux_pkg::*;
#(
    parameter int NR_OF_BITS = 8
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [NR_OF_BITS-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [NR_OF_BITS-1:0] o_data
`ifdef DEMUX_TRANSFER_COUNT_EN
   ,output cnt_t                  o_xfer_count
`endif
);

    logic                  r_valid;
    logic [NR_OF_BITS-1:0] r_data;
    logic                  w_drain;

    assign w_drain = r_valid && i_ready;

    // A load wins over a drain so a word can leave and arrive on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_drain) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

`ifdef DEMUX_TRANSFER_COUNT_EN
    cnt_t r_xfer_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_xfer_count <= '0;
        else if (w_drain)
            r_xfer_count <= r_xfer_count + 1'b1;
    end

    assign o_xfer_count = r_xfer_count;
`endif

endmodule

// File: rtl/stream_demultiplexer.sv
// Routes one valid/ready input stream to NR_OF_OUTPUTS buffered channels by Sel.
// Define DEMUX_TRANSFER_COUNT_EN to add per-channel transfer and drop counters.
module stream_demultiplexer
    import demux_pkg::*;
#(
    parameter  int NR_OF_OUTPUTS = 4,
    parameter  int NR_OF_BITS    = 8,
    localparam int SEL_BITS      = sel_bits(NR_OF_OUTPUTS)
)(
    input  logic                              Clock,
    input  logic                              Reset_n,
    input  logic                              Enable,
    input  logic [NR_OF_BITS-1:0]             DemuxIn,
    input  logic [SEL_BITS-1:0]               Sel,
    input  logic                              InValid,
    output logic                              InReady,
    output logic [NR_OF_OUTPUTS*NR_OF_BITS-1:0] DemuxOut,
    output logic [NR_OF_OUTPUTS-1:0]          OutValid,
    input  logic [NR_OF_OUTPUTS-1:0]          OutReady,
    output logic                              Dropped
`ifdef DEMUX_TRANSFER_COUNT_EN
   ,output logic [NR_OF_OUTPUTS*CNT_W-1:0]    XferCount,
    output logic [CNT_W-1:0]                  DropCount
`endif
);

    localparam logic [SEL_BITS:0] LP_NR_OUT = (SEL_BITS+1)'(NR_OF_OUTPUTS);

    logic [NR_OF_OUTPUTS-1:0] w_load;
    logic [NR_OF_OUTPUTS-1:0] w_valid;
    logic                     w_in_range;
    logic                     w_blocked;
    logic                     w_accept;
    logic                     r_dropped;

    assign w_in_range = ({1'b0, Sel} < LP_NR_OUT);

    // Only the addressed channel can stall the input; out-of-range selects never do.
    always_comb begin
        w_blocked = 1'b0;
        for (int k = 0; k < NR_OF_OUTPUTS; k++) begin
            if (Sel == SEL_BITS'(k))
                w_blocked = w_valid[k] && !OutReady[k];
        end
    end

    assign InReady  = Reset_n && Enable && !w_blocked;
    assign w_accept = InValid && InReady;

    for (genvar g = 0; g < NR_OF_OUTPUTS; g++) begin : g_slot
        assign w_load[g] = w_accept && (Sel == SEL_BITS'(g));

        demux_channel_slot #(
            .NR_OF_BITS (NR_OF_BITS)
        ) u_slot (
            .i_clk        (Clock),
            .i_rst_n      (Reset_n),
            .i_load       (w_load[g]),
            .i_data       (DemuxIn),
            .i_ready      (OutReady[g]),
            .o_valid      (w_valid[g]),
            .o_data       (DemuxOut[g*NR_OF_BITS +: NR_OF_BITS])
`ifdef DEMUX_TRANSFER_COUNT_EN
           ,.o_xfer_count (XferCount[g*CNT_W +: CNT_W])
`endif
        );
    end

    assign OutValid = w_valid;

    always_ff @(posedge Clock) begin
        if (!Reset_n)
            r_dropped <= 1'b0;
        else
            r_dropped <= w_accept && !w_in_range;
    end

    assign Dropped = r_dropped;

`ifdef DEMUX_TRANSFER_COUNT_EN
    cnt_t r_drop_count;

    always_ff @(posedge Clock) begin
        if (!Reset_n)
            r_drop_count <= '0;
        else if (w_accept && !w_in_range)
            r_drop_count <= r_drop_count + 1'b1;
    end

    assign DropCount = r_drop_count;
`endif

endmodule
